// File: rtl/day_counter_pkg.sv
// Shared calendar definitions for the lab3 day/month/year chain.
//   - field widths for day, month and year values
//   - month constants for the non-31-day months
//   - is_leap(): leap-year test for a 2000-based year offset
package day_counter_pkg;

  localparam int unsigned DAY_W   = 5;
  localparam int unsigned MONTH_W = 4;
  localparam int unsigned YEAR_W  = 7;

  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] APR = 4'd4;
  localparam logic [MONTH_W-1:0] JUN = 4'd6;
  localparam logic [MONTH_W-1:0] SEP = 4'd9;
  localparam logic [MONTH_W-1:0] NOV = 4'd11;

  // 2000..2099: every multiple of four is a leap year (2000 included).
  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    return (year[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/day_counter_days_in_month.sv
// Combinational days-in-month decoder.
//   i_month : month 1..12 (0 and 13..15 decode as 31 days)
//   i_leap  : current year is a leap year
//   o_dim   : number of days in the month, 28..31
module days_in_month
  import day_counter_pkg::*;
(
  input  logic [MONTH_W-1:0] i_month,
  input  logic               i_leap,
  output logic [DAY_W-1:0]   o_dim
);

  always_comb begin
    o_dim = 5'd31;
    case (i_month)
      APR, JUN, SEP, NOV: o_dim = 5'd30;
      FEB:                o_dim = i_leap ? 5'd29 : 5'd28;
      default:            ;
    endcase
  end

endmodule

// File: rtl/day_counter.sv
// Day-of-month counter feeding the month stage.
//   clk, rst_n   : clock, asynchronous active-low reset
//   inc_day      : one day per high cycle
//   i_month      : current month 1..12
//   i_year       : year offset 0..99 (2000..2099)
//   i_set        : load i_set_day (clamped to 1..dim), overrides inc_day
//   i_set_day    : day value to load
//   o_day        : current day 1..31
//   o_day_tens   : BCD tens digit of o_day
//   o_day_ones   : BCD ones digit of o_day
//   o_inc_month  : one-cycle strobe after a month wrap
module day_counter
  import day_counter_pkg::*;
#(
  parameter int unsigned LEAP_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc_day,
  input  logic [MONTH_W-1:0] i_month,
  input  logic [YEAR_W-1:0]  i_year,
  input  logic               i_set,
  input  logic [DAY_W-1:0]   i_set_day,
  output logic [DAY_W-1:0]   o_day,
  output logic [1:0]         o_day_tens,
  output logic [3:0]         o_day_ones,
  output logic               o_inc_month
);

  logic             leap;
  logic [DAY_W-1:0] dim;

  logic [DAY_W-1:0] day_d, day_q;
  logic [1:0]       tens_d, tens_q;
  logic [3:0]       ones_d, ones_q;
  logic             inc_month_d, inc_month_q;

  assign leap = (LEAP_EN != 0) && is_leap(i_year);

  days_in_month u_dim (
    .i_month (i_month),
    .i_leap  (leap),
    .o_dim   (dim)
  );

  // Priority: load, wrap, increment, clamp, hold.
  always_comb begin
    day_d       = day_q;
    inc_month_d = 1'b0;
    if (i_set) begin
      if (i_set_day == '0) begin
        day_d = 5'd1;
      end else if (i_set_day > dim) begin
        day_d = dim;
      end else begin
        day_d = i_set_day;
      end
    end else if (inc_day) begin
      if (day_q >= dim) begin
        day_d       = 5'd1;
        inc_month_d = 1'b1;
      end else begin
        day_d = day_q + 5'd1;
      end
    end else if (day_q > dim) begin
      // Month or year changed under us and the current day no longer exists.
      day_d = dim;
    end
  end

  // BCD digits derived from the next day so they register alongside it.
  always_comb begin
    if (day_d >= 5'd30) begin
      tens_d = 2'd3;
      ones_d = 4'(day_d - 5'd30);
    end else if (day_d >= 5'd20) begin
      tens_d = 2'd2;
      ones_d = 4'(day_d - 5'd20);
    end else if (day_d >= 5'd10) begin
      tens_d = 2'd1;
      ones_d = 4'(day_d - 5'd10);
    end else begin
      tens_d = 2'd0;
      ones_d = 4'(day_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q       <= 5'd1;
      tens_q      <= 2'd0;
      ones_q      <= 4'd1;
      inc_month_q <= 1'b0;
    end else begin
      day_q       <= day_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      inc_month_q <= inc_month_d;
    end
  end

  assign o_day       = day_q;
  assign o_day_tens  = tens_q;
  assign o_day_ones  = ones_q;
  assign o_inc_month = inc_month_q;

endmodule

// File: tb/tb_day_counter.sv
// Directed bench for day_counter: table of single-cycle vectors plus
// hand-written month runs and reset corner cases. A second instance with
// leap years disabled shares the inputs and is checked in the February runs.
module tb_day_counter;

  logic       clk;
  logic       rst_n;
  logic       inc_day;
  logic [3:0] i_month;
  logic [6:0] i_year;
  logic       i_set;
  logic [4:0] i_set_day;

  logic [4:0] o_day, nl_day;
  logic [1:0] o_day_tens, nl_tens;
  logic [3:0] o_day_ones, nl_ones;
  logic       o_inc_month, nl_inc;

  int checks = 0;
  int errors = 0;

  day_counter #(.LEAP_EN(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_day     (inc_day),
    .i_month     (i_month),
    .i_year      (i_year),
    .i_set       (i_set),
    .i_set_day   (i_set_day),
    .o_day       (o_day),
    .o_day_tens  (o_day_tens),
    .o_day_ones  (o_day_ones),
    .o_inc_month (o_inc_month)
  );

  day_counter #(.LEAP_EN(0)) dut_nl (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_day     (inc_day),
    .i_month     (i_month),
    .i_year      (i_year),
    .i_set       (i_set),
    .i_set_day   (i_set_day),
    .o_day       (nl_day),
    .o_day_tens  (nl_tens),
    .o_day_ones  (nl_ones),
    .o_inc_month (nl_inc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       set;
    logic       inc;
    logic [3:0] month;
    logic [6:0] year;
    logic [4:0] set_day;
    int         exp_day;
    int         exp_inc;
    string      name;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int day, input int strobe);
    chk({name, " day"},    int'(o_day),       day);
    chk({name, " tens"},   int'(o_day_tens),  day / 10);
    chk({name, " ones"},   int'(o_day_ones),  day % 10);
    chk({name, " strobe"}, int'(o_inc_month), strobe);
  endtask

  task automatic chk_nl(input string name, input int day, input int strobe);
    chk({name, " nl day"},    int'(nl_day),  day);
    chk({name, " nl tens"},   int'(nl_tens), day / 10);
    chk({name, " nl ones"},   int'(nl_ones), day % 10);
    chk({name, " nl strobe"}, int'(nl_inc),  strobe);
  endtask

  task automatic do_reset(input string name);
    inc_day = 1'b0;
    i_set   = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_out({name, " in reset"}, 1, 0);
    chk_nl({name, " in reset"}, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk_out({name, " after release"}, 1, 0);
  endtask

  // Hold inc_day high for n cycles from day 1; a = leap-enabled, b = leap-disabled.
  task automatic run_month(input string name, input int n, input int dim_a, input int dim_b);
    int da = 1;
    int db = 1;
    int sa, sb;
    int strobes_a = 0;
    inc_day = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      if (da >= dim_a) begin da = 1; sa = 1; end else begin da = da + 1; sa = 0; end
      if (db >= dim_b) begin db = 1; sb = 1; end else begin db = db + 1; sb = 0; end
      strobes_a += int'(o_inc_month);
      chk_out($sformatf("%s pulse %0d", name, k + 1), da, sa);
      chk_nl($sformatf("%s pulse %0d", name, k + 1), db, sb);
    end
    inc_day = 1'b0;
    tick();
    chk_out({name, " idle"}, da, 0);
    chk({name, " strobe count"}, strobes_a, (n >= dim_a) ? 1 : 0);
  endtask

  initial begin
    rst_n     = 1'b1;
    inc_day   = 1'b0;
    i_set     = 1'b0;
    i_set_day = 5'd0;
    i_month   = 4'd1;
    i_year    = 7'd0;

    //              set   inc   month  year   sd     day inc name
    vecs[0]  = '{1'b1, 1'b0, 4'd4,  7'd0,  5'd31, 30, 0, "apr set 31"};
    vecs[1]  = '{1'b1, 1'b0, 4'd4,  7'd0,  5'd0,  1,  0, "apr set 0"};
    vecs[2]  = '{1'b1, 1'b0, 4'd4,  7'd0,  5'd15, 15, 0, "apr set 15"};
    vecs[3]  = '{1'b1, 1'b0, 4'd4,  7'd0,  5'd30, 30, 0, "apr set 30"};
    vecs[4]  = '{1'b1, 1'b1, 4'd4,  7'd0,  5'd30, 30, 0, "set beats inc"};
    vecs[5]  = '{1'b0, 1'b1, 4'd4,  7'd0,  5'd0,  1,  1, "apr wrap"};
    vecs[6]  = '{1'b0, 1'b0, 4'd4,  7'd0,  5'd0,  1,  0, "apr idle"};
    vecs[7]  = '{1'b1, 1'b0, 4'd4,  7'd0,  5'd20, 20, 0, "apr set 20"};
    vecs[8]  = '{1'b0, 1'b1, 4'd4,  7'd0,  5'd0,  21, 0, "apr inc 21"};
    vecs[9]  = '{1'b1, 1'b0, 4'd1,  7'd0,  5'd31, 31, 0, "jan set 31"};
    vecs[10] = '{1'b0, 1'b0, 4'd4,  7'd0,  5'd0,  30, 0, "clamp to apr"};
    vecs[11] = '{1'b0, 1'b0, 4'd6,  7'd0,  5'd0,  30, 0, "jun hold"};
    vecs[12] = '{1'b1, 1'b0, 4'd0,  7'd0,  5'd31, 31, 0, "month0 set 31"};
    vecs[13] = '{1'b0, 1'b0, 4'd13, 7'd0,  5'd0,  31, 0, "month13 hold"};
    vecs[14] = '{1'b1, 1'b0, 4'd2,  7'd24, 5'd29, 29, 0, "feb24 set 29"};
    vecs[15] = '{1'b0, 1'b0, 4'd2,  7'd25, 5'd0,  28, 0, "year change clamp"};
    vecs[16] = '{1'b1, 1'b0, 4'd2,  7'd25, 5'd31, 28, 0, "feb25 set 31"};

    #2;
    do_reset("reset");

    // January: 30 pulses reach 31, the 31st wraps with one strobe.
    i_month = 4'd1;
    run_month("jan", 31, 31, 31);

    // February 2024 (leap) vs leap disabled.
    do_reset("reset feb24");
    i_month = 4'd2;
    i_year  = 7'd24;
    run_month("feb24", 29, 29, 28);

    // February 2023.
    do_reset("reset feb23");
    i_year = 7'd23;
    run_month("feb23", 28, 28, 28);

    // Single-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      i_set     = vecs[i].set;
      inc_day   = vecs[i].inc;
      i_month   = vecs[i].month;
      i_year    = vecs[i].year;
      i_set_day = vecs[i].set_day;
      tick();
      chk_out(vecs[i].name, vecs[i].exp_day, vecs[i].exp_inc);
    end
    i_set   = 1'b0;
    inc_day = 1'b0;

    // Month changes from January 31 to February 2023.
    i_month   = 4'd1;
    i_year    = 7'd0;
    i_set     = 1'b1;
    i_set_day = 5'd31;
    tick();
    i_set = 1'b0;
    chk_out("jan31 load", 31, 0);
    i_month = 4'd2;
    i_year  = 7'd23;
    tick();
    chk_out("jan31 to feb23", 28, 0);

    // Reset right after a wrap edge kills the strobe immediately.
    i_month = 4'd1;
    i_set   = 1'b1;
    tick();
    i_set   = 1'b0;
    inc_day = 1'b1;
    tick();
    inc_day = 1'b0;
    chk_out("wrap before reset", 1, 1);
    rst_n = 1'b0;
    #1;
    chk_out("reset kills strobe", 1, 0);
    #4;
    rst_n = 1'b1;
    tick();
    chk_out("after strobe reset", 1, 0);

    // Reset spanning the wrapping edge: the wrap is lost.
    i_set = 1'b1;
    tick();
    i_set = 1'b0;
    chk_out("reload 31", 31, 0);
    inc_day = 1'b1;
    #7;
    rst_n = 1'b0;
    #1;
    chk_out("reset over wrap", 1, 0);
    #4;
    rst_n   = 1'b1;
    inc_day = 1'b0;
    tick();
    chk_out("no strobe after reset", 1, 0);
    inc_day = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk_out($sformatf("resume %0d", k), k, 0);
    end
    inc_day = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
